buzzer_sfx: RTL and testbench

BUZZER_SFX -- requirements
Module: buzzer_sfx

---
 rtl/buzzer_sfx.sv | 214 +++++++++++++++++++++
 tb/tb_buzzer_sfx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_sfx.sv
`default_nettype none
// ============================================================================
//  Module   : buzzer_sfx
//  Purpose  : Sound-effect sequencer for a piezo buzzer. Game events are
//             latched as pending sounds and played one at a time, highest
//             priority first, from a fixed note table. Each note is a square
//             wave (half-period in clk cycles) lasting a number of video
//             frames, followed by a one-frame silent gap.
//  Ports    : clk             - 25 MHz system clock (only clock)
//             reset           - synchronous reset, active-high
//             startOfFrame    - one-cycle pulse at pixel (0,0)
//             player_died     - event pulse, sound 3 (highest priority)
//             alien_died      - event pulse, sound 2
//             player_eat_gold - event pulse, sound 1
//             fire_pressed    - shot button level, sound 0 on rising edge
//             buzzer          - square wave output
//             busy            - a sound is playing (NOTE or GAP)
//             sound_id        - sound being played, 0 when idle
//  Config   : SFX_PREEMPT_EN  - when defined, a pending sound of strictly
//             higher priority aborts the current sound immediately.
//  Revision : 1.0 - initial release
// ============================================================================
module buzzer_sfx (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       player_died,
    input  logic       alien_died,
    input  logic       player_eat_gold,
    input  logic       fire_pressed,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] sound_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_pending, w_pending_nxt;
    logic [3:0]  w_set;
    logic        r_fire_q;
    logic [1:0]  r_sound, w_sound_nxt;
    logic [1:0]  r_note, w_note_nxt;
    logic [14:0] r_hp_cnt, w_hp_cnt_nxt;
    logic [3:0]  r_frame_cnt, w_frame_cnt_nxt;
    logic        r_buzzer, w_buzzer_nxt;
    logic        w_any_pending;
    logic [1:0]  w_top_id;
    logic [14:0] w_half;
    logic        w_last_note;
    logic        w_preempt;
    logic        w_start;

    // Half-period of note idx of sound id, in clk cycles.
    function automatic logic [14:0] f_half_period(input logic [1:0] id, input logic [1:0] idx);
        logic [14:0] v;
        v = 15'd6250;
        case (id)
            2'd0: v = 15'd6250;
            2'd1: v = (idx == 2'd0) ? 15'd25000 : 15'd12500;
            2'd2: v = 15'd10000;
            default: begin
                case (idx)
                    2'd0:    v = 15'd12500;
                    2'd1:    v = 15'd18750;
                    default: v = 15'd25000;
                endcase
            end
        endcase
        return v;
    endfunction

    // Every note of a given sound lasts the same number of frames.
    function automatic logic [3:0] f_frames(input logic [1:0] id);
        logic [3:0] v;
        case (id)
            2'd0:    v = 4'd2;
            2'd1:    v = 4'd4;
            2'd2:    v = 4'd6;
            default: v = 4'd10;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] f_last_idx(input logic [1:0] id);
        logic [1:0] v;
        case (id)
            2'd1:    v = 2'd1;
            2'd3:    v = 2'd2;
            default: v = 2'd0;
        endcase
        return v;
    endfunction

    // Bit position equals sound_id, so priority is simply the highest set bit.
    assign w_set         = {player_died, alien_died, player_eat_gold, fire_pressed & ~r_fire_q};
    assign w_any_pending = |r_pending;
    assign w_half        = f_half_period(r_sound, r_note);
    assign w_last_note   = (r_note == f_last_idx(r_sound));

    always_comb begin
        w_top_id = 2'd0;
        if (r_pending[3])      w_top_id = 2'd3;
        else if (r_pending[2]) w_top_id = 2'd2;
        else if (r_pending[1]) w_top_id = 2'd1;
    end

`ifdef SFX_PREEMPT_EN
    assign w_preempt = w_any_pending && (w_top_id > r_sound);
`else
    assign w_preempt = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_sound_nxt     = r_sound;
        w_note_nxt      = r_note;
        w_hp_cnt_nxt    = r_hp_cnt;
        w_frame_cnt_nxt = r_frame_cnt;
        w_buzzer_nxt    = r_buzzer;
        w_pending_nxt   = r_pending | w_set;
        w_start         = 1'b0;

        case (r_state)
            IDLE: begin
                w_buzzer_nxt = 1'b0;
                if (w_any_pending) w_start = 1'b1;
            end
            NOTE: begin
                if (w_preempt) begin
                    w_start = 1'b1;
                end else begin
                    if (r_hp_cnt == w_half - 15'd1) begin
                        w_hp_cnt_nxt = 15'd0;
                        w_buzzer_nxt = ~r_buzzer;
                    end else begin
                        w_hp_cnt_nxt = r_hp_cnt + 15'd1;
                    end
                    // The partial frame after entry counts, so the note ends
                    // on the frame pulse that finds the counter at 1.
                    if (startOfFrame) begin
                        if (r_frame_cnt == 4'd1) begin
                            w_state_nxt  = GAP;
                            w_buzzer_nxt = 1'b0;
                            w_hp_cnt_nxt = 15'd0;
                        end else begin
                            w_frame_cnt_nxt = r_frame_cnt - 4'd1;
                        end
                    end
                end
            end
            GAP: begin
                w_buzzer_nxt = 1'b0;
                if (w_preempt) begin
                    w_start = 1'b1;
                end else if (startOfFrame) begin
                    if (w_last_note) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt     = NOTE;
                        w_note_nxt      = r_note + 2'd1;
                        w_hp_cnt_nxt    = 15'd0;
                        w_frame_cnt_nxt = f_frames(r_sound);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Starting a sound (from IDLE or by preemption) loads the highest
        // pending one and clears only its bit; a same-cycle re-trigger wins.
        if (w_start) begin
            w_state_nxt     = NOTE;
            w_sound_nxt     = w_top_id;
            w_note_nxt      = 2'd0;
            w_hp_cnt_nxt    = 15'd0;
            w_frame_cnt_nxt = f_frames(w_top_id);
            w_buzzer_nxt    = 1'b0;
            w_pending_nxt   = (r_pending & ~(4'b0001 << w_top_id)) | w_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pending   <= 4'd0;
            r_fire_q    <= 1'b0;
            r_sound     <= 2'd0;
            r_note      <= 2'd0;
            r_hp_cnt    <= 15'd0;
            r_frame_cnt <= 4'd0;
            r_buzzer    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_fire_q    <= fire_pressed;
            r_sound     <= w_sound_nxt;
            r_note      <= w_note_nxt;
            r_hp_cnt    <= w_hp_cnt_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_buzzer    <= w_buzzer_nxt;
        end
    end

    assign buzzer   = r_buzzer;
    assign busy     = (r_state != IDLE);
    assign sound_id = busy ? r_sound : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_sfx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_buzzer_sfx
//  Purpose  : Self-checking bench for buzzer_sfx. Stimulus pushes the
//             expected outputs of every clock into a queue; a monitor pops
//             and compares them against the DUT one step after each edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_sfx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       player_died = 1'b0;
    logic       alien_died = 1'b0;
    logic       player_eat_gold = 1'b0;
    logic       fire_pressed = 1'b0;
    logic       buzzer;
    logic       busy;
    logic [1:0] sound_id;

    buzzer_sfx dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .player_died    (player_died),
        .alien_died     (alien_died),
        .player_eat_gold(player_eat_gold),
        .fire_pressed   (fire_pressed),
        .buzzer         (buzzer),
        .busy           (busy),
        .sound_id       (sound_id)
    );

    always #5 clk = ~clk;

`ifdef SFX_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    typedef struct {
        int         t;
        logic       busy;
        logic [1:0] id;
        logic       bz;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: which sound/note is playing and since which cycle.
    bit m_pend[4];
    bit m_fire_prev;
    bit m_active;
    int m_sound;
    int m_note;
    bit m_gap;
    int m_t0;
    int m_frames;

    int cyc       = 0;
    int frame_len = 500;
    int fcnt      = 0;

    function automatic int half_of(input int s, input int n);
        case (s)
            0: return 6250;
            1: return (n == 0) ? 25000 : 12500;
            2: return 10000;
            default: return (n == 0) ? 12500 : ((n == 1) ? 18750 : 25000);
        endcase
    endfunction

    function automatic int frames_of(input int s);
        case (s)
            0: return 2;
            1: return 4;
            2: return 6;
            default: return 10;
        endcase
    endfunction

    function automatic int notes_of(input int s);
        case (s)
            1: return 2;
            3: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int top_pending();
        int top;
        top = -1;
        for (int s = 0; s < 4; s++) if (m_pend[s]) top = s;
        return top;
    endfunction

    function automatic bit model_idle();
        return !m_active && !m_pend[0] && !m_pend[1] && !m_pend[2] && !m_pend[3];
    endfunction

    task automatic model_step(input bit rst, input bit sof, input bit pd, input bit ad,
                              input bit ge, input bit fire);
        bit set_b[4];
        int top;
        if (rst) begin
            for (int s = 0; s < 4; s++) m_pend[s] = 1'b0;
            m_fire_prev = 1'b0;
            m_active    = 1'b0;
            m_gap       = 1'b0;
        end else begin
            set_b[0]    = fire && !m_fire_prev;
            set_b[1]    = ge;
            set_b[2]    = ad;
            set_b[3]    = pd;
            m_fire_prev = fire;
            top         = top_pending();
            if ((!m_active && top >= 0) || (m_active && PREEMPT && top > m_sound)) begin
                m_pend[top] = 1'b0;
                m_active    = 1'b1;
                m_sound     = top;
                m_note      = 0;
                m_gap       = 1'b0;
                m_t0        = cyc;
                m_frames    = 0;
            end else if (m_active && !m_gap) begin
                if (sof) begin
                    m_frames++;
                    if (m_frames == frames_of(m_sound)) m_gap = 1'b1;
                end
            end else if (m_active && sof) begin
                if (m_note + 1 < notes_of(m_sound)) begin
                    m_note++;
                    m_gap    = 1'b0;
                    m_t0     = cyc;
                    m_frames = 0;
                end else begin
                    m_active = 1'b0;
                end
            end
            for (int s = 0; s < 4; s++) if (set_b[s]) m_pend[s] = 1'b1;
        end
    endtask

    task automatic step(input bit rst, input bit pd, input bit ad, input bit ge, input bit fire);
        exp_t e;
        bit   sof;
        @(negedge clk);
        cyc++;
        sof  = (fcnt == frame_len - 1);
        fcnt = sof ? 0 : fcnt + 1;
        reset           = rst;
        startOfFrame    = sof;
        player_died     = pd;
        alien_died      = ad;
        player_eat_gold = ge;
        fire_pressed    = fire;
        model_step(rst, sof, pd, ad, ge, fire);
        e.t    = cyc;
        e.busy = m_active;
        e.id   = m_active ? 2'(m_sound) : 2'd0;
        e.bz   = (m_active && !m_gap) ? 1'(((cyc - m_t0) / half_of(m_sound, m_note)) % 2) : 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic run_idle(input int max_cyc);
        int n;
        n = 0;
        while (!model_idle() && n < max_cyc) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        if (!model_idle()) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: still busy after %0d cycles, want idle", max_cyc);
        end
        repeat (20) step(0, 0, 0, 0, 0);
    endtask

    task automatic set_frame(input int len);
        frame_len = len;
        fcnt      = 0;
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (busy !== e.busy || sound_id !== e.id || buzzer !== e.bz) begin
                    n_fail++;
                    $display("FAIL outputs@cyc%0d: got busy=%b id=%0d buzzer=%b, want busy=%b id=%0d buzzer=%b",
                             e.t, busy, sound_id, buzzer, e.busy, e.id, e.bz);
                end
            end
        end
    end

    initial begin
        bit fire_lvl;
        fire_lvl = 1'b0;
        for (int s = 0; s < 4; s++) m_pend[s] = 1'b0;
        m_fire_prev = 1'b0;
        m_active    = 1'b0;
        m_sound     = 0;
        m_note      = 0;
        m_gap       = 1'b0;
        m_t0        = 0;
        m_frames    = 0;

        // Reset state.
        repeat (3) step(1, 0, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0);

        // Single shot with frames long enough to see the 6250-cycle toggles.
        set_frame(6500);
        repeat (5) step(0, 0, 0, 0, 1);
        run_idle(40000);

        // Fire held for ten frames: a single shot, no replay.
        set_frame(1000);
        repeat (10000) step(0, 0, 0, 0, 1);
        run_idle(20000);

        // Three simultaneous events: died, alien, gold in that order.
        set_frame(400);
        step(0, 1, 1, 1, 0);
        run_idle(40000);

        // Gold playing, alien arrives during its first note.
        set_frame(500);
        step(0, 0, 0, 1, 0);
        repeat (100) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        run_idle(20000);

        // Reset in the middle of the died sound, with an event during reset.
        step(0, 1, 0, 0, 0);
        repeat (1200) step(0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1);
        repeat (50) step(0, 0, 0, 0, 0);

        // Randomized events, frame lengths, fire levels and resets.
        set_frame($urandom_range(150, 300));
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 499) == 0) fire_lvl = ~fire_lvl;
            step($urandom_range(0, 3999) == 0,
                 $urandom_range(0, 2999) == 0,
                 $urandom_range(0, 1999) == 0,
                 $urandom_range(0, 1499) == 0,
                 fire_lvl);
        end
        run_idle(30000);

        @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
